// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Turns single CPU load/store requests into word-wide accesses on a simple
// synchronous memory. Sub-word stores use read-modify-write so that only the
// addressed byte or halfword lane of the memory word changes.
//
// Parameters:
//   size          byte capacity of the attached memory
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         asynchronous active-high reset
//   req_valid     CPU request present
//   req_ready     unit idle; a request is accepted on req_valid && req_ready
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 reserved
//   req_signed    sign-extend sub-word loads
//   req_addr      byte address
//   req_wdata     store data, right-justified for sub-word stores
//   resp_valid    one-cycle completion pulse
//   resp_rdata    load result; 0 for stores and faults
//   resp_fault    access rejected
//   mem_enable    memory access strobe
//   mem_write     memory write select
//   mem_address   word-aligned memory address
//   mem_data_in   memory write data
//   mem_data_out  memory read data, valid the cycle after a read strobe
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned size = 64000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD      = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] MERGE   = 3'd3;
    localparam logic [2:0] WR      = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]  state_q,  state_d;
    logic        write_q,  write_d;
    logic [1:0]  size_q,   size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic        fault_q,  fault_d;
    // Captured memory word: read data for loads, write data for stores.
    logic [31:0] word_q,   word_d;

    logic        accept;
    logic        req_fault;
    logic [32:0] req_last_byte;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign accept = req_valid && (state_q == IDLE);

    // Bounds check uses the aligned word so a sub-word access to the last
    // partial word is also rejected; 33 bits keep the sum from wrapping.
    assign req_last_byte = {1'b0, req_addr[31:2], 2'b00} + 33'd3;

    always_comb begin
        req_fault = 1'b0;
        unique case (req_size)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = req_addr[0];
            SZ_WORD: req_fault = |req_addr[1:0];
            default: req_fault = 1'b1;
        endcase
        if (req_last_byte >= {1'b0, size}) begin
            req_fault = 1'b1;
        end
    end

    // Load lane extraction from the captured word (little-endian lanes).
    always_comb begin
        ld_byte = 8'h00;
        unique case (addr_q[1:0])
            2'd0: ld_byte = word_q[7:0];
            2'd1: ld_byte = word_q[15:8];
            2'd2: ld_byte = word_q[23:16];
            default: ld_byte = word_q[31:24];
        endcase
        ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];

        ld_data = word_q;
        if (size_q == SZ_BYTE) begin
            ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
        end else if (size_q == SZ_HALF) begin
            ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
        end
    end

    // Lane merge for sub-word stores: only the addressed lane is replaced.
    always_comb begin
        merged = mem_data_out;
        if (size_q == SZ_BYTE) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end
    end

    // Next-state and request latching.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fault_d  = fault_q;
        word_d   = word_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    fault_d  = req_fault;
                    word_d   = 32'h0;
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        // Full-word store needs no read: data goes straight out.
                        word_d  = req_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = write_q ? MERGE : RD_WAIT;
            end
            RD_WAIT: begin
                word_d  = mem_data_out;
                state_d = RESP;
            end
            MERGE: begin
                word_d  = merged;
                state_d = WR;
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            word_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
            word_q   <= word_d;
        end
    end

    // Outputs decode purely from state, so reset clears them immediately.
    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        resp_fault  = (state_q == RESP) && fault_q;
        resp_rdata  = 32'h0;
        if ((state_q == RESP) && !fault_q && !write_q) begin
            resp_rdata = ld_data;
        end
        mem_enable  = (state_q == RD) || (state_q == WR);
        mem_write   = (state_q == WR);
        mem_address = mem_enable ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_data_in = (state_q == WR) ? word_q : 32'h0;
    end

endmodule
